// File: rtl/wakeup_pkg.sv
// wakeup_pkg: shared types and the robid age-compare helper used by the
// wakeup broadcaster and the issue-queue flush logic.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 6
`endif

package wakeup_pkg;

  // Robid carries one extra MSB that toggles on every ROB wrap.
  localparam int ROBID_W = `ROB_SIZE_LOG + 1;
  localparam int COND_W  = 2;

  typedef logic [ROBID_W-1:0] robid_t;

  typedef struct packed {
    robid_t            robid;
    logic [COND_W-1:0] mask;
    logic [COND_W-1:0] cond;
  } wakeup_req_t;

  // True when robid is strictly younger than the flush point. The wrap bits
  // disagreeing inverts the sense of the low-bit compare; equal is not younger.
  function automatic logic robid_is_younger(robid_t flush_robid, robid_t robid);
    return flush_robid[ROBID_W-1] ^ robid[ROBID_W-1] ^
           (flush_robid[ROBID_W-2:0] < robid[ROBID_W-2:0]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant. Search starts at ptr and
// wraps; the first requester found wins. Pointer state lives in the caller.
module rr_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W:0] cand;
  logic           found;

  // Walk sources in priority order ptr, ptr+1, ... (mod NUM_SRC).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_SRC)) begin
        cand = cand - (IDX_W+1)'(NUM_SRC);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        grant_idx               = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wakeup_broadcaster.sv
// wakeup_broadcaster: arbitrates writeback wakeups from NUM_SRC sources,
// buffers them in a small FIFO and emits one condition-update pulse per cycle.
// Slots hold a live bit so a flush can kill buffered wakeups in place; dead
// slots still drain one per cycle but never broadcast.
// Optional feature: define WAKEUP_BYPASS_EN to let a granted request skip the
// empty FIFO and reach the output register one cycle earlier.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 6
`endif

module wakeup_broadcaster
  import wakeup_pkg::*;
#(
  parameter int NUM_SRC         = 3,
  parameter int CONDITION_WIDTH = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_SRC-1:0]                 src_valid,
  output logic [NUM_SRC-1:0]                 src_ready,
  input  logic [NUM_SRC*ROBID_W-1:0]         src_robid,
  input  logic [NUM_SRC*CONDITION_WIDTH-1:0] src_mask,
  input  logic [NUM_SRC*CONDITION_WIDTH-1:0] src_cond,
  input  logic                               flush_valid,
  input  logic [ROBID_W-1:0]                 flush_robid,
  output logic                               update_condition_valid,
  output logic [ROBID_W-1:0]                 update_condition_robid,
  output logic [CONDITION_WIDTH-1:0]         update_condition_mask,
  output logic [CONDITION_WIDTH-1:0]         update_condition_in,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // Per-source views of the flattened request buses.
  robid_t                     src_robid_arr [NUM_SRC];
  logic [CONDITION_WIDTH-1:0] src_mask_arr  [NUM_SRC];
  logic [CONDITION_WIDTH-1:0] src_cond_arr  [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_robid_arr[gi] = src_robid[gi*ROBID_W +: ROBID_W];
    assign src_mask_arr[gi]  = src_mask[gi*CONDITION_WIDTH +: CONDITION_WIDTH];
    assign src_cond_arr[gi]  = src_cond[gi*CONDITION_WIDTH +: CONDITION_WIDTH];
  end

  // Arbitration
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   rr_ptr_next;
  logic [NUM_SRC-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (src_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_any = |grant;

  // FIFO state
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [FIFO_DEPTH-1:0] slot_valid_reg;
  robid_t                     slot_robid [FIFO_DEPTH];
  logic [CONDITION_WIDTH-1:0] slot_mask  [FIFO_DEPTH];
  logic [CONDITION_WIDTH-1:0] slot_cond  [FIFO_DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bypass;

  robid_t                     sel_robid;
  logic [CONDITION_WIDTH-1:0] sel_mask;
  logic [CONDITION_WIDTH-1:0] sel_cond;
  logic                       in_live;
  logic                       head_live;
  logic [FIFO_DEPTH-1:0]      slot_flush_hit;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  assign src_ready = grant & {NUM_SRC{~full}};

  assign sel_robid = src_robid_arr[grant_idx];
  assign sel_mask  = src_mask_arr[grant_idx];
  assign sel_cond  = src_cond_arr[grant_idx];

  // An incoming request younger than a concurrent flush is accepted but dead.
  assign in_live = ~(flush_valid & robid_is_younger(flush_robid, sel_robid));

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_flush
    assign slot_flush_hit[gi] = flush_valid & robid_is_younger(flush_robid, slot_robid[gi]);
  end

  // Head is popped every non-empty cycle; it broadcasts only if still live.
  assign head_live = slot_valid_reg[head_reg] & ~slot_flush_hit[head_reg];

`ifdef WAKEUP_BYPASS_EN
  assign bypass = grant_any & empty;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = ~empty;
  assign push = grant_any & ~full & ~bypass;

  // Next round-robin pointer: one past the granted source, else hold.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_any) begin
      if (grant_idx == IDX_W'(NUM_SRC - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = grant_idx + 1'b1;
      end
    end
  end

  // Arbiter pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Head/tail pointers and occupancy; full/empty guard against over/underflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (pop) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Slot live bits: a push sets liveness, a pop retires the slot, a flush kills
  // younger slots. Push and pop never target the same slot in one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_reg <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push && tail_reg == PTR_W'(i)) begin
          slot_valid_reg[i] <= in_live;
        end else if (pop && head_reg == PTR_W'(i)) begin
          slot_valid_reg[i] <= 1'b0;
        end else if (slot_flush_hit[i]) begin
          slot_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Slot payload storage; contents are only meaningful behind a live bit.
  always_ff @(posedge clock) begin
    if (push) begin
      slot_robid[tail_reg] <= sel_robid;
      slot_mask[tail_reg]  <= sel_mask;
      slot_cond[tail_reg]  <= sel_cond;
    end
  end

  // Broadcast output register
  logic                       out_valid_reg;
  logic                       out_valid_next;
  robid_t                     out_robid_reg;
  robid_t                     out_robid_next;
  logic [CONDITION_WIDTH-1:0] out_mask_reg;
  logic [CONDITION_WIDTH-1:0] out_mask_next;
  logic [CONDITION_WIDTH-1:0] out_cond_reg;
  logic [CONDITION_WIDTH-1:0] out_cond_next;

  // Choose what the output register captures: live FIFO head, or the
  // bypassed request when the FIFO is empty; otherwise the pulse drops.
  always_comb begin
    out_valid_next = 1'b0;
    out_robid_next = out_robid_reg;
    out_mask_next  = out_mask_reg;
    out_cond_next  = out_cond_reg;
    if (pop) begin
      if (head_live) begin
        out_valid_next = 1'b1;
        out_robid_next = slot_robid[head_reg];
        out_mask_next  = slot_mask[head_reg];
        out_cond_next  = slot_cond[head_reg];
      end
    end else if (bypass && in_live) begin
      out_valid_next = 1'b1;
      out_robid_next = sel_robid;
      out_mask_next  = sel_mask;
      out_cond_next  = sel_cond;
    end
  end

  // Output register; valid is a single-cycle pulse, payload holds between pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      out_robid_reg <= '0;
      out_mask_reg  <= '0;
      out_cond_reg  <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_robid_reg <= out_robid_next;
      out_mask_reg  <= out_mask_next;
      out_cond_reg  <= out_cond_next;
    end
  end

  assign update_condition_valid = out_valid_reg;
  assign update_condition_robid = out_robid_reg;
  assign update_condition_mask  = out_mask_reg;
  assign update_condition_in    = out_cond_reg;
  assign fifo_count             = count_reg;

endmodule

// File: tb/tb_wakeup_broadcaster.sv
// tb_wakeup_broadcaster: directed self-checking bench for wakeup_broadcaster.
module tb_wakeup_broadcaster;
  import wakeup_pkg::*;

  localparam int NS = 3;
  localparam int CW = 2;
  localparam int RW = ROBID_W;
`ifdef WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clock;
  logic            reset_n;
  logic [NS-1:0]   src_valid;
  logic [NS-1:0]   src_ready;
  logic [NS*RW-1:0] src_robid;
  logic [NS*CW-1:0] src_mask;
  logic [NS*CW-1:0] src_cond;
  logic            flush_valid;
  logic [RW-1:0]   flush_robid;
  logic            update_condition_valid;
  logic [RW-1:0]   update_condition_robid;
  logic [CW-1:0]   update_condition_mask;
  logic [CW-1:0]   update_condition_in;
  logic [2:0]      fifo_count;

  int tests_run;
  int tests_failed;

  logic [RW-1:0] bcast_robid_q[$];
  logic [CW-1:0] bcast_mask_q[$];
  logic [CW-1:0] bcast_cond_q[$];

  wakeup_broadcaster #(
    .NUM_SRC         (NS),
    .CONDITION_WIDTH (CW),
    .FIFO_DEPTH      (4)
  ) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .src_valid              (src_valid),
    .src_ready              (src_ready),
    .src_robid              (src_robid),
    .src_mask               (src_mask),
    .src_cond               (src_cond),
    .flush_valid            (flush_valid),
    .flush_robid            (flush_robid),
    .update_condition_valid (update_condition_valid),
    .update_condition_robid (update_condition_robid),
    .update_condition_mask  (update_condition_mask),
    .update_condition_in    (update_condition_in),
    .fifo_count             (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every broadcast pulse, sampled away from the active edge.
  always @(negedge clock) begin
    if (update_condition_valid === 1'b1) begin
      bcast_robid_q.push_back(update_condition_robid);
      bcast_mask_q.push_back(update_condition_mask);
      bcast_cond_q.push_back(update_condition_in);
      $display("[TB] broadcast robid=%0d mask=%b in=%b count=%0d",
               update_condition_robid, update_condition_mask, update_condition_in, fifo_count);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_src(input int idx, input logic v, input logic [RW-1:0] r,
                           input logic [CW-1:0] m, input logic [CW-1:0] c);
    src_valid[idx]           = v;
    src_robid[idx*RW +: RW]  = r;
    src_mask[idx*CW +: CW]   = m;
    src_cond[idx*CW +: CW]   = c;
  endtask

  task automatic clear_queues();
    bcast_robid_q.delete();
    bcast_mask_q.delete();
    bcast_cond_q.delete();
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    src_valid   = '0;
    src_robid   = '0;
    src_mask    = '0;
    src_cond    = '0;
    flush_valid = 1'b0;
    flush_robid = '0;
    #1;
    tests_run++;
    if (update_condition_valid !== 1'b0 || update_condition_robid !== '0 ||
        update_condition_mask !== '0 || update_condition_in !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got v=%b r=%0d m=%b i=%b, required all 0",
               update_condition_valid, update_condition_robid, update_condition_mask, update_condition_in);
    end
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count: got %0d, required 0", fifo_count);
    end
    src_valid = 3'b111;
    #1;
    tests_run++;
    if (src_ready !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b, required 001", src_ready);
    end
    src_valid = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
    $display("[TB] reset released");
  endtask

  task automatic test_rr();
    logic [RW-1:0] exp_robid [6];
    logic [NS-1:0] exp_ready;
    exp_robid = '{7'd10, 7'd20, 7'd30, 7'd10, 7'd20, 7'd30};
    clear_queues();
    drive_src(0, 1'b1, 7'd10, 2'b01, 2'b00);
    drive_src(1, 1'b1, 7'd20, 2'b10, 2'b10);
    drive_src(2, 1'b1, 7'd30, 2'b11, 2'b01);
    #1;
    for (int c = 0; c < 6; c++) begin
      exp_ready = 3'b001 << (c % 3);
      tests_run++;
      if (src_ready !== exp_ready) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant cycle %0d: got %b, required %b", c, src_ready, exp_ready);
      end
      step();
      tests_run++;
      if (fifo_count !== (BYP ? 3'd0 : 3'd1)) begin
        tests_failed++;
        $display("[TB] FAIL rr_count cycle %0d: got %0d, required %0d", c, fifo_count, BYP ? 0 : 1);
      end
    end
    src_valid = '0;
    repeat (3) step();
    tests_run++;
    if (bcast_robid_q.size() != 6) begin
      tests_failed++;
      $display("[TB] FAIL rr_pulses: got %0d, required 6", bcast_robid_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (bcast_robid_q[i] !== exp_robid[i]) begin
          tests_failed++;
          $display("[TB] FAIL rr_order %0d: got robid %0d, required %0d", i, bcast_robid_q[i], exp_robid[i]);
        end
      end
    end
    $display("[TB] rr test done");
  endtask

  task automatic test_single();
    clear_queues();
    drive_src(1, 1'b1, 7'd5, 2'b01, 2'b01);
    #1;
    tests_run++;
    if (src_ready !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL single_ready: got %b, required 010", src_ready);
    end
    step();
    src_valid = '0;
    tests_run++;
    if (update_condition_valid !== BYP) begin
      tests_failed++;
      $display("[TB] FAIL single_lat1: got valid %b, required %b", update_condition_valid, BYP);
    end
    step();
    tests_run++;
    if (update_condition_valid !== ~BYP || update_condition_robid !== 7'd5) begin
      tests_failed++;
      $display("[TB] FAIL single_lat2: got valid %b robid %0d, required valid %b robid 5",
               update_condition_valid, update_condition_robid, ~BYP);
    end
    step();
    tests_run++;
    if (update_condition_valid !== 1'b0 || fifo_count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL single_idle: got valid %b count %0d, required 0 0", update_condition_valid, fifo_count);
    end
    tests_run++;
    if (bcast_robid_q.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL single_pulses: got %0d, required 1", bcast_robid_q.size());
    end else if (bcast_robid_q[0] !== 7'd5 || bcast_mask_q[0] !== 2'b01 || bcast_cond_q[0] !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL single_payload: got r=%0d m=%b c=%b, required r=5 m=01 c=01",
               bcast_robid_q[0], bcast_mask_q[0], bcast_cond_q[0]);
    end
    $display("[TB] single test done");
  endtask

  task automatic test_back_to_back();
    clear_queues();
    drive_src(2, 1'b1, 7'd40, 2'b10, 2'b10);
    #1;
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (src_ready !== 3'b100) begin
        tests_failed++;
        $display("[TB] FAIL b2b_ready cycle %0d: got %b, required 100", c, src_ready);
      end
      step();
    end
    src_valid = '0;
    repeat (3) step();
    tests_run++;
    if (bcast_robid_q.size() != 5) begin
      tests_failed++;
      $display("[TB] FAIL b2b_pulses: got %0d, required 5", bcast_robid_q.size());
    end
    $display("[TB] back-to-back test done");
  endtask

  task automatic test_flush();
    clear_queues();
    drive_src(0, 1'b1, 7'd3, 2'b11, 2'b11);
    step();
    drive_src(0, 1'b1, 7'd8, 2'b11, 2'b11);
    step();
    drive_src(0, 1'b1, 7'd10, 2'b11, 2'b11);
    flush_valid = 1'b1;
    flush_robid = 7'd7;
    step();
    src_valid   = '0;
    flush_valid = 1'b0;
    tests_run++;
    if (update_condition_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_head_drop: got valid %b robid %0d, required valid 0",
               update_condition_valid, update_condition_robid);
    end
    tests_run++;
    if (fifo_count !== (BYP ? 3'd0 : 3'd1)) begin
      tests_failed++;
      $display("[TB] FAIL flush_dead_slot: got count %0d, required %0d", fifo_count, BYP ? 0 : 1);
    end
    repeat (3) step();
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL flush_drain: got count %0d, required 0", fifo_count);
    end
    tests_run++;
    if (bcast_robid_q.size() != (BYP ? 2 : 1)) begin
      tests_failed++;
      $display("[TB] FAIL flush_pulses: got %0d, required %0d", bcast_robid_q.size(), BYP ? 2 : 1);
    end else if (bcast_robid_q[0] !== 7'd3) begin
      tests_failed++;
      $display("[TB] FAIL flush_survivor: got robid %0d, required 3", bcast_robid_q[0]);
    end
    $display("[TB] flush test done");
  endtask

  task automatic test_wrap();
    clear_queues();
    drive_src(0, 1'b1, {1'b0, 6'd60}, 2'b01, 2'b00);
    step();
    drive_src(0, 1'b1, {1'b1, 6'd4}, 2'b01, 2'b00);
    flush_valid = 1'b1;
    flush_robid = {1'b1, 6'd2};
    step();
    src_valid   = '0;
    flush_valid = 1'b0;
    tests_run++;
    if (update_condition_valid !== ~BYP) begin
      tests_failed++;
      $display("[TB] FAIL wrap_head: got valid %b robid %0d, required valid %b",
               update_condition_valid, update_condition_robid, ~BYP);
    end
    repeat (3) step();
    tests_run++;
    if (bcast_robid_q.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_pulses: got %0d, required 1", bcast_robid_q.size());
    end else if (bcast_robid_q[0] !== {1'b0, 6'd60}) begin
      tests_failed++;
      $display("[TB] FAIL wrap_survivor: got robid %0d, required 60", bcast_robid_q[0]);
    end
    $display("[TB] wrap test done");
  endtask

  task automatic test_reset_mid();
    drive_src(0, 1'b1, 7'd12, 2'b01, 2'b01);
    step();
    drive_src(0, 1'b1, 7'd13, 2'b01, 2'b01);
    step();
    #1;
    reset_n = 1'b0;
    #1;
    clear_queues();
    tests_run++;
    if (update_condition_valid !== 1'b0 || update_condition_robid !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_outputs: got valid %b robid %0d, required 0 0",
               update_condition_valid, update_condition_robid);
    end
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_count: got %0d, required 0", fifo_count);
    end
    src_valid = '0;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    tests_run++;
    if (bcast_robid_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_pulses: got %0d, required 0", bcast_robid_q.size());
    end
    $display("[TB] mid-operation reset test done");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_rr();
    test_single();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
